// File: rtl/axis_pkg.sv
// Shared definitions for the AXI4-Stream receive stage: default widths,
// the stored beat layout and the derived pointer width.
package axis_pkg;

    localparam int DEFAULT_DATA_W = 32;
    localparam int DEFAULT_DEPTH  = 4;

    // Pointer index width for the default depth; the wrap bit sits above it
    localparam int DEFAULT_PTR_W  = $clog2(DEFAULT_DEPTH);

    // One stored beat at the default width: frame-end flag above the payload
    typedef struct packed {
        logic                      last;
        logic [DEFAULT_DATA_W-1:0] data;
    } axis_beat_t;

endpackage

// File: rtl/axis_fifo_mem.sv
// Beat storage: DEPTH x W register array, one synchronous write port and
// one asynchronous read port so the head entry is visible show-ahead.
module axis_fifo_mem #(
    parameter int W     = 33,
    parameter int DEPTH = 4,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          aclk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [W-1:0]  wdata,
    input  logic [AW-1:0] raddr,
    output logic [W-1:0]  rdata
);

    logic [W-1:0] mem [DEPTH];

    // Store the incoming beat; contents are deliberately left unreset
    always_ff @(posedge aclk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/axis_s.sv
// AXI4-Stream slave receive stage: accepts beats into a small show-ahead
// FIFO, presents the head to a local pop interface and counts completed
// frames as their tlast beat is popped.
module axis_s
    import axis_pkg::*;
#(
    parameter int DATA_W = DEFAULT_DATA_W,
    parameter int DEPTH  = DEFAULT_DEPTH,
    parameter int CNT_W  = 16
) (
    input  logic                     aclk,
    input  logic                     areset,
    input  logic                     tvalid,
    output logic                     tready,
    input  logic [DATA_W-1:0]        tdata,
    input  logic                     tlast,
    input  logic                     rd_en,
    output logic [DATA_W-1:0]        rd_data,
    output logic                     rd_last,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     frame_done,
    output logic [CNT_W-1:0]         frame_cnt
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0]       wr_ptr_reg;
    logic [AW:0]       rd_ptr_reg;
    logic [AW:0]       level_w;
    logic              full;
    logic              wr;
    logic              rd;
    logic [DATA_W:0]   head_beat;
    logic [DATA_W:0]   hold_reg;
    logic              frame_done_reg;
    logic [CNT_W-1:0]  frame_cnt_reg;

    // Occupancy comes from the wrap-bit pointer difference, so it is purely registered
    assign level_w = wr_ptr_reg - rd_ptr_reg;
    assign full    = (level_w == (AW+1)'(DEPTH));
    assign empty   = (level_w == '0);
    assign level   = level_w;

    assign tready  = ~full & ~areset;
    assign wr      = tvalid & tready;
    assign rd      = rd_en & ~empty;

    axis_fifo_mem #(
        .W     (DATA_W + 1),
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_mem (
        .aclk  (aclk),
        .we    (wr),
        .waddr (wr_ptr_reg[AW-1:0]),
        .wdata ({tlast, tdata}),
        .raddr (rd_ptr_reg[AW-1:0]),
        .rdata (head_beat)
    );

    // While empty the consumer sees the last popped beat (zero after reset)
    assign rd_data = empty ? hold_reg[DATA_W-1:0] : head_beat[DATA_W-1:0];
    assign rd_last = empty ? hold_reg[DATA_W]     : head_beat[DATA_W];

    // Advance write and read pointers on their handshakes
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
        end else begin
            if (wr) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            if (rd) begin
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            end
        end
    end

    // Capture each popped beat so the outputs hold steady once drained
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            hold_reg <= '0;
        end else if (rd) begin
            hold_reg <= head_beat;
        end
    end

    // Pulse frame_done and bump the wrapping frame counter when a tlast beat is popped
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            frame_done_reg <= 1'b0;
            frame_cnt_reg  <= '0;
        end else begin
            frame_done_reg <= rd & head_beat[DATA_W];
            if (rd & head_beat[DATA_W]) begin
                frame_cnt_reg <= frame_cnt_reg + CNT_W'(1);
            end
        end
    end

    assign frame_done = frame_done_reg;
    assign frame_cnt  = frame_cnt_reg;

endmodule

// File: tb/tb_axis_s.sv
// Self-checking bench for axis_s: scoreboard queue of accepted beats,
// popped and compared as the consumer reads them.
module tb_axis_s;
    import axis_pkg::*;

    localparam int DATA_W = 32;
    localparam int DEPTH  = 4;
    localparam int CNT_W  = 2;
    localparam int LW     = $clog2(DEPTH) + 1;

    logic              aclk = 1'b0;
    logic              areset;
    logic              tvalid;
    logic              tready;
    logic [DATA_W-1:0] tdata;
    logic              tlast;
    logic              rd_en;
    logic [DATA_W-1:0] rd_data;
    logic              rd_last;
    logic              empty;
    logic [LW-1:0]     level;
    logic              frame_done;
    logic [CNT_W-1:0]  frame_cnt;

    int n_cmp = 0;
    int n_err = 0;

    axis_beat_t       exp_q[$];
    logic [CNT_W-1:0] mdl_cnt;
    logic             exp_fd;

    // Results of the most recent cycle
    logic             did_wr;
    logic             did_rd;
    axis_beat_t       got_beat;
    axis_beat_t       exp_beat;

    always #5 aclk = ~aclk;

    axis_s #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .CNT_W  (CNT_W)
    ) dut (
        .aclk       (aclk),
        .areset     (areset),
        .tvalid     (tvalid),
        .tready     (tready),
        .tdata      (tdata),
        .tlast      (tlast),
        .rd_en      (rd_en),
        .rd_data    (rd_data),
        .rd_last    (rd_last),
        .empty      (empty),
        .level      (level),
        .frame_done (frame_done),
        .frame_cnt  (frame_cnt)
    );

    // Drive one clock cycle starting at a negedge; updates the scoreboard
    // and the frame model, returns at the following negedge.
    task automatic cyc(input logic v, input logic [DATA_W-1:0] d, input logic l, input logic r);
        tvalid = v;
        tdata  = d;
        tlast  = l;
        rd_en  = r;
        #1;
        did_wr   = v && tready;
        did_rd   = r && !empty;
        got_beat = {rd_last, rd_data};
        exp_beat = 'x;
        exp_fd   = 1'b0;
        if (did_rd) begin
            if (exp_q.size() > 0) begin
                exp_beat = exp_q.pop_front();
                if (exp_beat.last) begin
                    exp_fd  = 1'b1;
                    mdl_cnt = mdl_cnt + 1'b1;
                end
            end
        end
        if (did_wr) exp_q.push_back('{last: l, data: d});
        @(negedge aclk);
    endtask

    task automatic test_reset();
        n_cmp++; if (tready !== 1'b0) begin n_err++; $display("FAIL reset_tready: got %b want 0", tready); end
        n_cmp++; if (empty !== 1'b1) begin n_err++; $display("FAIL reset_empty: got %b want 1", empty); end
        n_cmp++; if (level !== '0) begin n_err++; $display("FAIL reset_level: got %0d want 0", level); end
        n_cmp++; if (frame_done !== 1'b0 || frame_cnt !== '0) begin n_err++; $display("FAIL reset_frame: got done=%b cnt=%0d want 0/0", frame_done, frame_cnt); end
        n_cmp++; if (rd_data !== '0 || rd_last !== 1'b0) begin n_err++; $display("FAIL reset_rd: got %h/%b want 0/0", rd_data, rd_last); end
        areset = 1'b0;
        @(negedge aclk);
        n_cmp++; if (tready !== 1'b1) begin n_err++; $display("FAIL release_tready: got %b want 1", tready); end
        $display("test_reset done");
    endtask

    task automatic test_single_beat();
        cyc(1'b1, 32'hDEADBEEF, 1'b1, 1'b0);
        tvalid = 1'b0;
        n_cmp++; if (empty !== 1'b0 || rd_data !== 32'hDEADBEEF || rd_last !== 1'b1) begin
            n_err++; $display("FAIL single_head: got empty=%b %h/%b want 0 deadbeef/1", empty, rd_data, rd_last); end
        cyc(1'b0, '0, 1'b0, 1'b1);
        n_cmp++; if (got_beat !== exp_beat) begin n_err++; $display("FAIL single_pop: got %h want %h", got_beat, exp_beat); end
        n_cmp++; if (frame_done !== 1'b1 || frame_cnt !== 2'd1 || empty !== 1'b1) begin
            n_err++; $display("FAIL single_frame: got done=%b cnt=%0d empty=%b want 1/1/1", frame_done, frame_cnt, empty); end
        cyc(1'b0, '0, 1'b0, 1'b0);
        n_cmp++; if (frame_done !== 1'b0) begin n_err++; $display("FAIL single_pulse: got %b want 0", frame_done); end
        $display("test_single_beat done");
    endtask

    task automatic test_fill();
        logic [DATA_W-1:0] nxt = 32'h1;
        for (int i = 0; i < 4; i++) begin
            cyc(1'b1, nxt, 1'b0, 1'b0);
            if (did_wr) nxt++;
        end
        n_cmp++; if (tready !== 1'b0 || level !== LW'(4)) begin
            n_err++; $display("FAIL fill_full: got tready=%b level=%0d want 0/4", tready, level); end
        // Master stalls holding 0x5 while one entry is popped
        cyc(1'b1, nxt, 1'b0, 1'b1);
        n_cmp++; if (did_wr !== 1'b0) begin n_err++; $display("FAIL fill_stall: got wr=%b want 0", did_wr); end
        n_cmp++; if (got_beat !== exp_beat) begin n_err++; $display("FAIL fill_pop: got %h want %h", got_beat, exp_beat); end
        n_cmp++; if (tready !== 1'b1) begin n_err++; $display("FAIL fill_recover: got tready=%b want 1", tready); end
        for (int i = 0; i < 12 && exp_q.size() + (nxt <= 6 ? 1 : 0) > 0; i++) begin
            cyc(nxt <= 6, nxt, 1'b0, 1'b1);
            if (did_wr) nxt++;
            if (did_rd) begin
                n_cmp++; if (got_beat !== exp_beat) begin n_err++; $display("FAIL fill_order: got %h want %h", got_beat, exp_beat); end
            end
        end
        n_cmp++; if (nxt !== 32'h7 || empty !== 1'b1) begin n_err++; $display("FAIL fill_drain: got next=%0d empty=%b want 7/1", nxt, empty); end
        $display("test_fill done");
    endtask

    task automatic test_simul();
        cyc(1'b1, 32'h100, 1'b0, 1'b0);
        cyc(1'b1, 32'h101, 1'b0, 1'b0);
        for (int i = 0; i < 10; i++) begin
            cyc(1'b1, 32'h102 + 32'(i), 1'b0, 1'b1);
            n_cmp++; if (got_beat !== exp_beat || !did_rd) begin n_err++; $display("FAIL simul_data: got %h want %h", got_beat, exp_beat); end
            n_cmp++; if (level !== LW'(exp_q.size()) || level !== LW'(2)) begin
                n_err++; $display("FAIL simul_level: got %0d want 2", level); end
        end
        for (int i = 0; i < 2; i++) begin
            cyc(1'b0, '0, 1'b0, 1'b1);
            n_cmp++; if (got_beat !== exp_beat) begin n_err++; $display("FAIL simul_drain: got %h want %h", got_beat, exp_beat); end
        end
        $display("test_simul done");
    endtask

    task automatic test_empty_pop();
        logic [CNT_W-1:0] cnt0 = frame_cnt;
        for (int i = 0; i < 3; i++) begin
            cyc(1'b0, '0, 1'b0, 1'b1);
            n_cmp++; if (level !== '0 || frame_done !== 1'b0 || frame_cnt !== cnt0) begin
                n_err++; $display("FAIL empty_pop: got level=%0d done=%b cnt=%0d want 0/0/%0d", level, frame_done, frame_cnt, cnt0); end
        end
        cyc(1'b1, 32'hA5, 1'b0, 1'b0);
        n_cmp++; if (rd_data !== 32'hA5 || level !== LW'(1)) begin n_err++; $display("FAIL empty_a5: got %h lvl=%0d want a5/1", rd_data, level); end
        cyc(1'b0, '0, 1'b0, 1'b1);
        n_cmp++; if (got_beat !== exp_beat) begin n_err++; $display("FAIL empty_pop_a5: got %h want %h", got_beat, exp_beat); end
        $display("test_empty_pop done");
    endtask

    task automatic test_wrap();
        for (int i = 0; i < 5; i++) begin
            cyc(1'b1, 32'h200 + 32'(i), 1'b1, 1'b0);
            cyc(1'b0, '0, 1'b0, 1'b1);
            n_cmp++; if (frame_cnt !== mdl_cnt || frame_done !== exp_fd || exp_fd !== 1'b1) begin
                n_err++; $display("FAIL wrap_cnt: got cnt=%0d done=%b want %0d/1", frame_cnt, frame_done, mdl_cnt); end
            $display("wrap frame %0d cnt=%0d", i, frame_cnt);
        end
        $display("test_wrap done");
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 3; i++) cyc(1'b1, 32'h300 + 32'(i), 1'b0, 1'b0);
        n_cmp++; if (level !== LW'(3)) begin n_err++; $display("FAIL mid_level3: got %0d want 3", level); end
        tvalid = 1'b1;
        tdata  = 32'h3FF;
        #2 areset = 1'b1;
        #1;
        n_cmp++; if (tready !== 1'b0 || empty !== 1'b1 || level !== '0) begin
            n_err++; $display("FAIL mid_reset: got tready=%b empty=%b level=%0d want 0/1/0", tready, empty, level); end
        exp_q.delete();
        mdl_cnt = '0;
        @(negedge aclk);
        areset = 1'b0;
        cyc(1'b1, 32'h55, 1'b0, 1'b0);
        tvalid = 1'b0;
        n_cmp++; if (rd_data !== 32'h55 || level !== LW'(1) || frame_cnt !== '0) begin
            n_err++; $display("FAIL mid_head: got %h lvl=%0d cnt=%0d want 55/1/0", rd_data, level, frame_cnt); end
        cyc(1'b0, '0, 1'b0, 1'b1);
        n_cmp++; if (got_beat !== exp_beat) begin n_err++; $display("FAIL mid_pop: got %h want %h", got_beat, exp_beat); end
        $display("test_reset_mid done");
    endtask

    initial begin
        areset  = 1'b1;
        tvalid  = 1'b0;
        tdata   = '0;
        tlast   = 1'b0;
        rd_en   = 1'b0;
        mdl_cnt = '0;
        exp_fd  = 1'b0;
        repeat (2) @(negedge aclk);
        test_reset();
        test_single_beat();
        test_fill();
        test_simul();
        test_empty_pop();
        test_wrap();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    // Overall time limit so the run always ends
    initial begin
        #200000;
        $display("FAIL timeout: bench did not complete");
        $fatal(1, "timeout");
    end

endmodule
